// File: rtl/mem_pkg.sv
// Packet-memory geometry and shared types for the buffer write and read paths.
// Blocks are 64 bytes: a 16-bit footer in the low bits and up to 62 payload bytes above it.
package mem_pkg;

  localparam int unsigned ADDR_W        = 14;
  localparam int unsigned BLOCK_BYTES   = 64;
  localparam int unsigned PAYLOAD_BYTES = 62;
  localparam int unsigned BLOCK_BITS    = BLOCK_BYTES * 8;
  localparam int unsigned FOOTER_BITS   = 16;
  localparam int unsigned PAYLOAD_BITS  = PAYLOAD_BYTES * 8;
  localparam int unsigned PTR_W         = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] next_idx;
    logic              eop;
    logic              rsvd;
  } footer_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitData,
    StStream,
    StFree
  } rd_state_t;

endpackage

// File: rtl/memory_read_ctrl_if.sv
// Descriptor, packet-memory, free-list and egress signals of the frame read controller.
// Signal suffixes are from the controller's point of view; the controller uses the master modport.
interface memory_read_ctrl_if #(
  parameter int unsigned LEN_W = 11
) ();
  import mem_pkg::*;

  logic                  rd_req_i;
  logic [ADDR_W-1:0]     rd_start_addr_i;
  logic [LEN_W-1:0]      rd_len_i;
  logic                  rd_ready_o;

  logic                  mem_re_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic                  mem_ready_i;
  logic                  mem_rvalid_i;
  logic [BLOCK_BITS-1:0] mem_rdata_i;

  logic                  fl_free_req_o;
  logic [ADDR_W-1:0]     fl_free_idx_o;
  logic                  fl_free_gnt_i;

  logic [7:0]            data_o;
  logic                  data_valid_o;
  logic                  data_begin_o;
  logic                  data_end_o;
  logic                  data_ready_i;

  logic                  err_o;

  modport master (
    input  rd_req_i, rd_start_addr_i, rd_len_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
           fl_free_gnt_i, data_ready_i,
    output rd_ready_o, mem_re_o, mem_addr_o, fl_free_req_o, fl_free_idx_o, data_o,
           data_valid_o, data_begin_o, data_end_o, err_o
  );

  modport slave (
    output rd_req_i, rd_start_addr_i, rd_len_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
           fl_free_gnt_i, data_ready_i,
    input  rd_ready_o, mem_re_o, mem_addr_o, fl_free_req_o, fl_free_idx_o, data_o,
           data_valid_o, data_begin_o, data_end_o, err_o
  );

endinterface

// File: rtl/memory_read_ctrl.sv
// Walks a frame's block chain in packet memory, streams the payload one byte per beat and
// returns every consumed block to the free list.
module memory_read_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned LEN_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  memory_read_ctrl_if.master bus
);

  rd_state_t               state_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [ADDR_W-1:0]       next_q;
  logic [LEN_W-1:0]        rem_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        n_q;
  logic [PAYLOAD_BITS-1:0] blk_q;
  logic                    first_q;
  logic                    trunc_q;
  logic                    err_pend_q;
  logic                    rd_ready_q;
  logic                    mem_re_q;
  logic                    free_req_q;
  logic                    valid_q;

  footer_t                 footer;
  logic                    rem_gt_blk;
  logic [PTR_W-1:0]        blk_n;
  logic [PTR_W-1:0]        sel;
  logic                    last_beat;
  logic                    unused_rsvd;

  assign footer      = footer_t'(bus.mem_rdata_i[FOOTER_BITS-1:0]);
  assign unused_rsvd = footer.rsvd;

  // Bytes held by the block being fetched follow from the remaining length, not the footer.
  assign rem_gt_blk = rem_q > LEN_W'(PAYLOAD_BYTES);
  assign blk_n      = rem_gt_blk ? PTR_W'(PAYLOAD_BYTES) : rem_q[PTR_W-1:0];
  assign last_beat  = ptr_q == (n_q - PTR_W'(1));

  // Payload is right-justified, so byte 0 of an n-byte block sits highest.
  assign sel = n_q - PTR_W'(1) - ptr_q;

  assign bus.rd_ready_o    = rd_ready_q;
  assign bus.mem_re_o      = mem_re_q;
  assign bus.mem_addr_o    = idx_q;
  assign bus.fl_free_req_o = free_req_q;
  assign bus.fl_free_idx_o = idx_q;
  assign bus.data_valid_o  = valid_q;
  assign bus.data_o        = valid_q ? blk_q[{sel, 3'b000} +: 8] : 8'h00;
  assign bus.data_begin_o  = valid_q && first_q;
  assign bus.data_end_o    = valid_q && ((rem_q == LEN_W'(1)) || (trunc_q && last_beat));
  assign bus.err_o         = free_req_q && bus.fl_free_gnt_i && err_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      next_q     <= '0;
      rem_q      <= '0;
      ptr_q      <= '0;
      n_q        <= '0;
      blk_q      <= '0;
      first_q    <= 1'b0;
      trunc_q    <= 1'b0;
      err_pend_q <= 1'b0;
      rd_ready_q <= 1'b0;
      mem_re_q   <= 1'b0;
      free_req_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rd_ready_q <= 1'b1;
          if (rd_ready_q && bus.rd_req_i) begin
            rd_ready_q <= 1'b0;
            idx_q      <= bus.rd_start_addr_i;
            rem_q      <= bus.rd_len_i;
            first_q    <= 1'b1;
            trunc_q    <= 1'b0;
            if (bus.rd_len_i == '0) begin
              // Empty frame: release the start block unread and flag it.
              err_pend_q <= 1'b1;
              free_req_q <= 1'b1;
              state_q    <= StFree;
            end else begin
              err_pend_q <= 1'b0;
              mem_re_q   <= 1'b1;
              state_q    <= StFetch;
            end
          end
        end
        StFetch: begin
          if (bus.mem_ready_i) begin
            mem_re_q <= 1'b0;
            state_q  <= StWaitData;
          end
        end
        StWaitData: begin
          if (bus.mem_rvalid_i) begin
            blk_q      <= bus.mem_rdata_i[BLOCK_BITS-1:FOOTER_BITS];
            ptr_q      <= '0;
            n_q        <= blk_n;
            next_q     <= footer.next_idx;
            // eop early truncates the frame; missing eop on the final block is only reported.
            trunc_q    <= footer.eop && rem_gt_blk;
            err_pend_q <= footer.eop ? rem_gt_blk : !rem_gt_blk;
            valid_q    <= 1'b1;
            state_q    <= StStream;
          end
        end
        StStream: begin
          if (bus.data_ready_i) begin
            ptr_q   <= ptr_q + PTR_W'(1);
            rem_q   <= rem_q - LEN_W'(1);
            first_q <= 1'b0;
            if (last_beat) begin
              valid_q    <= 1'b0;
              free_req_q <= 1'b1;
              state_q    <= StFree;
            end
          end
        end
        StFree: begin
          if (bus.fl_free_gnt_i) begin
            free_req_q <= 1'b0;
            if (rem_q == '0 || trunc_q) begin
              rd_ready_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              idx_q    <= next_q;
              mem_re_q <= 1'b1;
              state_q  <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_read_ctrl.sv
// Bench for memory_read_ctrl: directed and random frames scored against a frame-level model
// built from the block chain written into a behavioural packet memory.
module tb_memory_read_ctrl;
  import mem_pkg::*;

  localparam int unsigned LEN_W    = 11;
  localparam int unsigned MAX_WAIT = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_read_ctrl_if #(.LEN_W(LEN_W)) bus ();
  memory_read_ctrl #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [BLOCK_BITS-1:0] mem_img [int unsigned];
  logic [7:0]            pbytes  [int unsigned];
  int unsigned           nxt_of  [int unsigned];
  bit                    eop_of  [int unsigned];
  int unsigned           chain_q [$];
  bit                    eop_q   [$];

  logic [9:0]  exp_beats[$];
  int unsigned exp_rd[$];
  int unsigned exp_fr[$];
  int          exp_err;
  logic [9:0]  obs_beats[$];
  int unsigned obs_rd[$];
  int unsigned obs_fr[$];
  int          obs_err;
  int          stall_cycles;
  int          stall_bad;

  int unsigned mem_dly    = 0;
  int unsigned gnt_dly    = 0;
  bit          ready_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BLOCK_BITS-1:0] rand_block();
    logic [BLOCK_BITS-1:0] b;
    for (int w = 0; w < BLOCK_BITS / 32; w++) b[32*w +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [31:0] ctl_outs();
    return 32'({bus.mem_re_o, bus.fl_free_req_o, bus.data_valid_o, bus.data_begin_o,
                bus.data_end_o, bus.err_o, bus.data_o});
  endfunction

  // Writer side: lays chain_q/eop_q down as right-justified blocks for a frame of len bytes.
  task automatic write_chain(input int unsigned len);
    int unsigned rem = len;
    for (int k = 0; k < chain_q.size(); k++) begin
      int unsigned           idx = chain_q[k];
      int unsigned           n   = (rem > PAYLOAD_BYTES) ? PAYLOAD_BYTES : rem;
      logic [BLOCK_BITS-1:0] blk = rand_block();
      footer_t               ft;
      for (int unsigned i = 0; i < n; i++) begin
        logic [7:0] b = 8'($urandom());
        pbytes[idx*64 + i] = b;
        blk[FOOTER_BITS + 8*(n-1-i) +: 8] = b;
      end
      ft.next_idx = (k + 1 < chain_q.size()) ? ADDR_W'(chain_q[k+1]) : ADDR_W'($urandom());
      ft.eop      = eop_q[k];
      ft.rsvd     = 1'b0;
      blk[FOOTER_BITS-1:0] = ft;
      mem_img[idx] = blk;
      nxt_of[idx]  = 32'(ft.next_idx);
      eop_of[idx]  = eop_q[k];
      rem = rem - n;
    end
  endtask

  // Frame-level expectation: byte list with begin/end flags, read and free order, error pulses.
  task automatic model(input int unsigned start, input int unsigned len);
    int unsigned rem = len;
    int unsigned idx = start;
    int unsigned n;
    exp_beats.delete();
    exp_rd.delete();
    exp_fr.delete();
    exp_err = 0;
    if (len == 0) begin
      exp_fr.push_back(start);
      exp_err = 1;
      return;
    end
    forever begin
      exp_rd.push_back(idx);
      n = (rem > PAYLOAD_BYTES) ? PAYLOAD_BYTES : rem;
      for (int unsigned i = 0; i < n; i++)
        exp_beats.push_back({exp_beats.size() == 0,
                             (rem - i == 1) || (i == n - 1 && eop_of[idx] && rem > n),
                             pbytes[idx*64 + i]});
      exp_fr.push_back(idx);
      if (eop_of[idx] && rem > n) begin
        exp_err = 1;
        break;
      end
      rem -= n;
      if (rem == 0) begin
        exp_err = eop_of[idx] ? 0 : 1;
        break;
      end
      idx = nxt_of[idx];
    end
  endtask

  // Memory, free list and sink responders; all inputs change on the falling edge.
  initial begin : env
    logic [9:0]            prev_beat;
    logic [9:0]            cur_beat;
    bit                    prev_stall;
    bit                    rv_pend;
    logic [BLOCK_BITS-1:0] rv_data;
    int unsigned           mem_wait;
    int unsigned           gnt_wait;
    prev_beat  = '0;
    prev_stall = 1'b0;
    rv_pend    = 1'b0;
    rv_data    = '0;
    mem_wait   = 0;
    gnt_wait   = 0;
    bus.mem_ready_i   = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = '0;
    bus.fl_free_gnt_i = 1'b0;
    bus.data_ready_i  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.mem_ready_i   = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.fl_free_gnt_i = 1'b0;
        bus.data_ready_i  = 1'b0;
        prev_stall = 1'b0;
        rv_pend    = 1'b0;
        mem_wait   = 0;
        gnt_wait   = 0;
      end else begin
        bus.mem_rvalid_i = rv_pend;
        bus.mem_rdata_i  = rv_pend ? rv_data : rand_block();
        rv_pend          = 1'b0;
        bus.mem_ready_i  = 1'b0;
        if (bus.mem_re_o) begin
          if (mem_wait >= mem_dly) begin
            bus.mem_ready_i = 1'b1;
            mem_wait = 0;
            rv_pend  = 1'b1;
            obs_rd.push_back(32'(bus.mem_addr_o));
            rv_data = mem_img.exists(32'(bus.mem_addr_o)) ? mem_img[32'(bus.mem_addr_o)]
                                                         : rand_block();
          end else mem_wait++;
        end
        bus.fl_free_gnt_i = 1'b0;
        if (bus.fl_free_req_o) begin
          if (gnt_wait >= gnt_dly) begin
            bus.fl_free_gnt_i = 1'b1;
            gnt_wait = 0;
            obs_fr.push_back(32'(bus.fl_free_idx_o));
          end else gnt_wait++;
        end
        bus.data_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        cur_beat = {bus.data_begin_o, bus.data_end_o, bus.data_o};
        if (prev_stall) begin
          stall_cycles++;
          if (!bus.data_valid_o || cur_beat !== prev_beat) stall_bad++;
        end
        if (bus.data_valid_o && bus.data_ready_i) obs_beats.push_back(cur_beat);
        prev_stall = bus.data_valid_o && !bus.data_ready_i;
        prev_beat  = cur_beat;
        #1;
        if (bus.err_o === 1'b1) obs_err++;
      end
    end
  end

  task automatic send_desc(input int unsigned start, input int unsigned len, input bit timing);
    int unsigned guard = 0;
    obs_beats.delete();
    obs_rd.delete();
    obs_fr.delete();
    obs_err = 0;
    model(start, len);
    bus.rd_req_i        = 1'b1;
    bus.rd_start_addr_i = ADDR_W'(start);
    bus.rd_len_i        = LEN_W'(len);
    while (bus.rd_ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("accept", 32'(guard < 100), 1);
    @(negedge clk);
    bus.rd_req_i = 1'b0;
    if (timing) begin
      chk("mem_re_T+1", 32'(bus.mem_re_o), 1);
      chk("mem_addr_T+1", 32'(bus.mem_addr_o), start);
      chk("rd_ready_busy", 32'(bus.rd_ready_o), 0);
      repeat (2) @(negedge clk);
      chk("valid_T+3", 32'(bus.data_valid_o), 1);
      chk("begin_T+3", 32'(bus.data_begin_o), 1);
    end
  endtask

  task automatic wait_done();
    int unsigned guard = 0;
    while (!(obs_fr.size() >= exp_fr.size() && bus.rd_ready_o === 1'b1) && guard < MAX_WAIT)
    begin
      @(negedge clk);
      guard++;
    end
    chk("frame_done", 32'(guard < MAX_WAIT), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, ".nbytes"}, obs_beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++)
      chk($sformatf("%s.beat%0d", tag, i), 32'(obs_beats[i]), 32'(exp_beats[i]));
    chk({tag, ".nreads"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      chk($sformatf("%s.read%0d", tag, i), obs_rd[i], exp_rd[i]);
    chk({tag, ".nfrees"}, obs_fr.size(), exp_fr.size());
    for (int i = 0; i < exp_fr.size() && i < obs_fr.size(); i++)
      chk($sformatf("%s.free%0d", tag, i), obs_fr[i], exp_fr[i]);
    chk({tag, ".err"}, obs_err, exp_err);
  endtask

  task automatic run_frame(input string tag, input int unsigned start, input int unsigned len,
                           input bit timing);
    send_desc(start, len, timing);
    wait_done();
    check_frame(tag);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int unsigned guard;
    bus.rd_req_i        = 1'b0;
    bus.rd_start_addr_i = '0;
    bus.rd_len_i        = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.rd_ready", 32'(bus.rd_ready_o), 0);
    chk("rst.ctl", ctl_outs(), 0);
    chk("rst.addrs", 32'({bus.mem_addr_o, bus.fl_free_idx_o}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready_after", 32'(bus.rd_ready_o), 1);

    chain_q = '{5};         eop_q = '{1'b1};             write_chain(10);
    run_frame("len10", 5, 10, 1'b1);
    chain_q = '{3, 7, 9};   eop_q = '{1'b0, 1'b0, 1'b1}; write_chain(130);
    run_frame("len130", 3, 130, 1'b1);
    chain_q = '{20};        eop_q = '{1'b1};             write_chain(62);
    run_frame("len62", 20, 62, 1'b1);
    chain_q = '{30};        eop_q = '{1'b1};             write_chain(100);
    run_frame("trunc100", 30, 100, 1'b0);
    chain_q = '{40};        eop_q = '{1'b1};             write_chain(0);
    run_frame("len0", 40, 0, 1'b0);
    chain_q = '{50, 51};    eop_q = '{1'b0, 1'b0};       write_chain(70);
    run_frame("noeop70", 50, 70, 1'b0);

    // Backpressure everywhere: same frame 3->7->9 must come out identically.
    ready_rand   = 1'b1;
    mem_dly      = 3;
    gnt_dly      = 3;
    stall_cycles = 0;
    stall_bad    = 0;
    run_frame("stall130", 3, 130, 1'b0);
    chk("stall.stable", stall_bad, 0);
    chk("stall.seen", 32'(stall_cycles > 0), 1);

    for (int k = 0; k < 4; k++) begin
      int unsigned len = $urandom_range(1, 400);
      int unsigned nb  = (len + PAYLOAD_BYTES - 1) / PAYLOAD_BYTES;
      chain_q.delete();
      eop_q.delete();
      for (int unsigned j = 0; j < nb; j++) begin
        chain_q.push_back(2000 + 16*k + 3*j);
        eop_q.push_back(j == nb - 1);
      end
      write_chain(len);
      mem_dly    = $urandom_range(0, 2);
      gnt_dly    = $urandom_range(0, 2);
      ready_rand = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", k), chain_q[0], len, 1'b0);
    end

    mem_dly    = 0;
    gnt_dly    = 0;
    ready_rand = 1'b0;
    send_desc(3, 130, 1'b0);
    guard = 0;
    while (obs_beats.size() < 20 && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_mid.reached", 32'(guard < MAX_WAIT), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid.rd_ready", 32'(bus.rd_ready_o), 0);
    chk("rst_mid.ctl", ctl_outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.ready_after", 32'(bus.rd_ready_o), 1);
    run_frame("after_rst", 5, 10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
